seed_extend_seq: RTL and testbench

- Hardware sequencer that runs FM-index bidirectional extension over a whole query held in an internal buffer.
- Issues one extension request per symbol to an Extension core through its start/finish handshake.
- Modes: forward-only, backward-only, or forward-then-backward. A direction stops when the interval size falls below a programmable minimum, an ambiguous symbol is reached, or the query end is reached.
- Reports the final bi-interval and query span. It replaces testbench-driven stepping and feeds downstream SMEM collection.

---
 rtl/seed_extend_seq_pkg.sv | 50 +++++
 rtl/seed_extend_seq_query_ram.sv | 22 ++
 rtl/seed_extend_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_seed_extend_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_extend_seq_pkg.sv
// Shared constants, payload types and enums for the FM-index seed extension sequencer.
package seed_extend_seq_pkg;

  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned AW      = $clog2(MAX_LEN);
  localparam int unsigned KLS_W   = 40;
  localparam int unsigned SYM_W   = 3;

  typedef logic [SYM_W-1:0] symbol_t;
  typedef logic [KLS_W-1:0] kls_t;

  // Symbol codes at or above this value are ambiguous (N and friends).
  localparam symbol_t SYM_AMBIG_MIN = SYM_W'(4);

  localparam logic DirForward  = 1'b0;
  localparam logic DirBackward = 1'b1;

  typedef struct packed {
    kls_t k;
    kls_t l;
    kls_t s;
  } bi_intv_t;

  typedef enum logic [1:0] {
    MODE_FWD   = 2'd0,
    MODE_BWD   = 2'd1,
    MODE_BIDIR = 2'd2
  } seq_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD_RD,
    ST_FWD_REQ,
    ST_FWD_WAIT,
    ST_BWD_RD,
    ST_BWD_REQ,
    ST_BWD_WAIT,
    ST_DONE
  } seq_state_e;

  // The reserved mode encoding behaves as forward-then-backward.
  function automatic seq_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_FWD;
      2'd1:    return MODE_BWD;
      default: return MODE_BIDIR;
    endcase
  endfunction

endpackage

// File: rtl/seed_extend_seq_query_ram.sv
// Query symbol buffer: one write port, one synchronous read port (1-cycle latency).
module seq_query_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/seed_extend_seq.sv
// Sequences bidirectional FM-index extension over a buffered query, one core request per symbol.
module seed_extend_seq
  import seed_extend_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [KLS_W-1:0] cfg_bwt_len,
  input  logic             q_wr,
  input  logic [AW-1:0]    q_addr,
  input  logic [SYM_W-1:0] q_sym,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AW:0]      q_len,
  input  logic [AW-1:0]    pivot,
  input  logic [KLS_W-1:0] min_intv,
  output logic             busy,
  output logic             res_valid,
  output logic [KLS_W-1:0] res_k,
  output logic [KLS_W-1:0] res_l,
  output logic [KLS_W-1:0] res_s,
  output logic [AW-1:0]    res_beg,
  output logic [AW:0]      res_end,
  output logic [SYM_W-1:0] ext_a,
  output logic             ext_dir,
  output logic [KLS_W-1:0] ext_k,
  output logic [KLS_W-1:0] ext_l,
  output logic [KLS_W-1:0] ext_s,
  output logic             ext_start,
  input  logic [KLS_W-1:0] ext_k_in,
  input  logic [KLS_W-1:0] ext_l_in,
  input  logic [KLS_W-1:0] ext_s_in,
  input  logic             ext_finish
);

  seq_state_e state_q, state_d;
  seq_mode_e  mode_q, mode_d;
  bi_intv_t   intv_q, intv_d, ext_q, ext_d, res_q, res_d, core_res;
  logic [AW-1:0] pos_q, pos_d, pivot_q, pivot_d, beg_q, beg_d, res_beg_q, res_beg_d;
  logic [AW:0]   end_q, end_d, qlen_q, qlen_d, res_end_q, res_end_d;
  kls_t          min_q, min_d, bwt_len_q, bwt_len_d;
  symbol_t       ext_a_q, ext_a_d, rd_data;
  logic          busy_q, busy_d, res_valid_q, res_valid_d, ext_start_q, ext_start_d;
  logic          ext_dir_q, ext_dir_d;
  logic          ram_we, accept, fwd_last;
  seq_state_e    fwd_exit;

  seq_query_ram #(.DEPTH(MAX_LEN), .WIDTH(SYM_W), .ADDR_W(AW)) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (q_addr),
    .wr_data (q_sym),
    .rd_addr (pos_q),
    .rd_data (rd_data)
  );

  assign core_res = '{k: ext_k_in, l: ext_l_in, s: ext_s_in};
  assign accept   = (ext_s_in != '0) && (ext_s_in >= min_q);
  assign fwd_last = ({1'b0, pos_q} == (qlen_q - (AW+1)'(1)));
  // Forward hands over to backward only in bidirectional mode with room left of the pivot.
  assign fwd_exit = (mode_q == MODE_BIDIR && pivot_q != '0) ? ST_BWD_RD : ST_DONE;
  assign ram_we   = q_wr && (state_q == ST_IDLE) && !busy_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    intv_d      = intv_q;
    pos_d       = pos_q;
    beg_d       = beg_q;
    end_d       = end_q;
    qlen_d      = qlen_q;
    pivot_d     = pivot_q;
    min_d       = min_q;
    bwt_len_d   = cfg_valid ? cfg_bwt_len : bwt_len_q;
    busy_d      = busy_q && !res_valid_q;
    res_valid_d = 1'b0;
    res_d       = res_q;
    res_beg_d   = res_beg_q;
    res_end_d   = res_end_q;
    ext_start_d = 1'b0;
    ext_a_d     = ext_a_q;
    ext_dir_d   = ext_dir_q;
    ext_d       = ext_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          busy_d  = 1'b1;
          qlen_d  = q_len;
          pivot_d = pivot;
          min_d   = min_intv;
          mode_d  = decode_mode(mode);
          intv_d  = '{k: '0, l: '0, s: bwt_len_q};
          pos_d   = pivot;
          beg_d   = pivot;
          end_d   = {1'b0, pivot};
          if (q_len == '0 || {1'b0, pivot} >= q_len) state_d = ST_DONE;
          else if (decode_mode(mode) == MODE_BWD)    state_d = ST_BWD_RD;
          else                                       state_d = ST_FWD_RD;
        end
      end
      ST_FWD_RD: state_d = ST_FWD_REQ;
      ST_FWD_REQ: begin
        if (rd_data >= SYM_AMBIG_MIN) begin
          state_d = fwd_exit;
          pos_d   = pivot_q - AW'(1);
        end else begin
          ext_start_d = 1'b1;
          ext_a_d     = rd_data;
          ext_dir_d   = DirForward;
          ext_d       = intv_q;
          state_d     = ST_FWD_WAIT;
        end
      end
      ST_FWD_WAIT: begin
        if (ext_finish) begin
          if (accept) begin
            intv_d = core_res;
            end_d  = {1'b0, pos_q} + (AW+1)'(1);
          end
          if (accept && !fwd_last) begin
            pos_d   = pos_q + AW'(1);
            state_d = ST_FWD_RD;
          end else begin
            pos_d   = pivot_q - AW'(1);
            state_d = fwd_exit;
          end
        end
      end
      ST_BWD_RD: state_d = ST_BWD_REQ;
      ST_BWD_REQ: begin
        if (rd_data >= SYM_AMBIG_MIN) begin
          state_d = ST_DONE;
        end else begin
          ext_start_d = 1'b1;
          ext_a_d     = rd_data;
          ext_dir_d   = DirBackward;
          ext_d       = intv_q;
          state_d     = ST_BWD_WAIT;
        end
      end
      ST_BWD_WAIT: begin
        if (ext_finish) begin
          if (accept) begin
            intv_d = core_res;
            beg_d  = pos_q;
            // Backward-only runs cover the pivot itself once anything is accepted.
            if (mode_q == MODE_BWD) end_d = {1'b0, pivot_q} + (AW+1)'(1);
          end
          if (accept && pos_q != '0) begin
            pos_d   = pos_q - AW'(1);
            state_d = ST_BWD_RD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        res_valid_d = 1'b1;
        res_d       = intv_q;
        res_beg_d   = beg_q;
        res_end_d   = end_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_FWD;
      intv_q      <= '0;
      pos_q       <= '0;
      beg_q       <= '0;
      end_q       <= '0;
      qlen_q      <= '0;
      pivot_q     <= '0;
      min_q       <= '0;
      bwt_len_q   <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_beg_q   <= '0;
      res_end_q   <= '0;
      ext_start_q <= 1'b0;
      ext_a_q     <= '0;
      ext_dir_q   <= 1'b0;
      ext_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      intv_q      <= intv_d;
      pos_q       <= pos_d;
      beg_q       <= beg_d;
      end_q       <= end_d;
      qlen_q      <= qlen_d;
      pivot_q     <= pivot_d;
      min_q       <= min_d;
      bwt_len_q   <= bwt_len_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_beg_q   <= res_beg_d;
      res_end_q   <= res_end_d;
      ext_start_q <= ext_start_d;
      ext_a_q     <= ext_a_d;
      ext_dir_q   <= ext_dir_d;
      ext_q       <= ext_d;
    end
  end

  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_k     = res_q.k;
  assign res_l     = res_q.l;
  assign res_s     = res_q.s;
  assign res_beg   = res_beg_q;
  assign res_end   = res_end_q;
  assign ext_start = ext_start_q;
  assign ext_a     = ext_a_q;
  assign ext_dir   = ext_dir_q;
  assign ext_k     = ext_q.k;
  assign ext_l     = ext_q.l;
  assign ext_s     = ext_q.s;

endmodule

// File: tb/tb_seed_extend_seq.sv
// Bench for seed_extend_seq: mock extension core plus a plain-arithmetic model of the extension walk.
module tb_seed_extend_seq;
  import seed_extend_seq_pkg::*;

  localparam int BUDGET = 4000;

  typedef struct {
    kls_t k, l, s;
    int   beg, fin, nreq, lat;
    logic busy_after;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_valid = 1'b0, q_wr = 1'b0, start = 1'b0, ext_finish = 1'b0;
  kls_t cfg_bwt_len = '0, min_intv = '0;
  logic [AW-1:0] q_addr = '0, pivot = '0;
  symbol_t q_sym = '0;
  logic [1:0] mode = '0;
  logic [AW:0] q_len = '0;
  kls_t ext_k_in = '0, ext_l_in = '0, ext_s_in = '0;
  logic busy, res_valid, ext_dir, ext_start;
  kls_t res_k, res_l, res_s, ext_k, ext_l, ext_s;
  logic [AW-1:0] res_beg;
  logic [AW:0] res_end;
  symbol_t ext_a;

  int checks = 0, errors = 0;
  int core_lat = 3, core_cnt = 0, n_req = 0, n_res = 0, inj_req = 0, inj_ack = 0, req_base = 0;
  kls_t hold_k, hold_l, hold_s;
  symbol_t qbuf [MAX_LEN];

  always #5 clk = ~clk;

  seed_extend_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bwt_len(cfg_bwt_len),
    .q_wr(q_wr), .q_addr(q_addr), .q_sym(q_sym), .start(start), .mode(mode),
    .q_len(q_len), .pivot(pivot), .min_intv(min_intv), .busy(busy), .res_valid(res_valid),
    .res_k(res_k), .res_l(res_l), .res_s(res_s), .res_beg(res_beg), .res_end(res_end),
    .ext_a(ext_a), .ext_dir(ext_dir), .ext_k(ext_k), .ext_l(ext_l), .ext_s(ext_s),
    .ext_start(ext_start), .ext_k_in(ext_k_in), .ext_l_in(ext_l_in), .ext_s_in(ext_s_in),
    .ext_finish(ext_finish)
  );

  // Mock core: answers (k+1, l+1, s>>1) core_lat cycles after a request; can inject a stray finish.
  always @(negedge clk) begin
    ext_finish = 1'b0;
    if (!rst_n) core_cnt = 0;
    else if (ext_start) begin
      n_req++;
      hold_k = ext_k; hold_l = ext_l; hold_s = ext_s;
      core_cnt = core_lat;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        ext_finish = 1'b1;
        ext_k_in = hold_k + 1; ext_l_in = hold_l + 1; ext_s_in = hold_s >> 1;
      end
    end
    if (inj_req != inj_ack) begin
      inj_ack = inj_req;
      ext_finish = 1'b1;
      ext_k_in = 40'd7; ext_l_in = 40'd7; ext_s_in = 40'd20;
    end
  end

  always @(negedge clk) if (res_valid) n_res++;

  function automatic res_t model(input int md, input int ql, input int pv, input kls_t mv, input kls_t bwt);
    res_t r;
    kls_t ns;
    int   bstart;
    bit   do_bwd;
    r.k = '0; r.l = '0; r.s = bwt; r.beg = pv; r.fin = pv; r.nreq = 0; r.lat = 0; r.busy_after = 1'b0;
    if (ql == 0 || pv >= ql) return r;
    if (md == 3) md = 2;
    if (md != 1) begin
      for (int p = pv; p < ql; p++) begin
        if (qbuf[p] >= 4) break;
        r.nreq++;
        ns = r.s >> 1;
        if (ns == 0 || ns < mv) break;
        r.k++; r.l++; r.s = ns; r.fin = p + 1;
      end
    end
    do_bwd = (md == 1) || (md == 2 && pv > 0);
    bstart = (md == 1) ? pv : pv - 1;
    if (do_bwd) begin
      for (int p = bstart; p >= 0; p--) begin
        if (qbuf[p] >= 4) break;
        r.nreq++;
        ns = r.s >> 1;
        if (ns == 0 || ns < mv) break;
        r.k++; r.l++; r.s = ns; r.beg = p;
        if (md == 1) r.fin = pv + 1;
      end
    end
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("k=%0d l=%0d s=%0d beg=%0d end=%0d req=%0d", r.k, r.l, r.s, r.beg, r.fin, r.nreq);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; q_wr = 1'b0; cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_bwt(input kls_t v);
    @(negedge clk); cfg_valid = 1'b1; cfg_bwt_len = v;
    @(negedge clk); cfg_valid = 1'b0;
  endtask

  task automatic load_query(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); q_wr = 1'b1; q_addr = AW'(i); q_sym = qbuf[i];
    end
    @(negedge clk); q_wr = 1'b0;
  endtask

  task automatic kick(input int md, input int ql, input int pv, input kls_t mv);
    @(negedge clk);
    mode = 2'(md); q_len = (AW+1)'(ql); pivot = AW'(pv); min_intv = mv; start = 1'b1;
    req_base = n_req;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_result(output res_t o);
    bit ok = 1'b0;
    o.lat = 1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
      o.lat++;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL result_timeout: no res_valid within %0d cycles", BUDGET); end
    o.k = res_k; o.l = res_l; o.s = res_s; o.beg = int'(res_beg); o.fin = int'(res_end);
    o.nreq = n_req - req_base;
    @(negedge clk);
    o.busy_after = busy;
  endtask

  task automatic run(input int md, input int ql, input int pv, input kls_t mv, output res_t o);
    kick(md, ql, pv, mv);
    wait_result(o);
  endtask

  task automatic fill_a(input int n);
    for (int i = 0; i < n; i++) qbuf[i] = 3'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (ext_start !== 1'b0) begin errors++; $display("FAIL reset_ext_start: got %b want 0", ext_start); end
    checks++; if ({res_k, res_l, res_s} !== '0) begin errors++; $display("FAIL reset_res_kls: got %0d/%0d/%0d want 0", res_k, res_l, res_s); end
    checks++; if ({res_beg, res_end} !== '0) begin errors++; $display("FAIL reset_res_span: got %0d/%0d want 0", res_beg, res_end); end
    checks++; if ({ext_a, ext_dir, ext_k, ext_l, ext_s} !== '0) begin errors++; $display("FAIL reset_ext: got a=%0d d=%b s=%0d want 0", ext_a, ext_dir, ext_s); end
  endtask

  task automatic test_forward();
    res_t o, e;
    set_bwt(40'd64); fill_a(10); load_query(10);
    run(0, 10, 0, 40'd4, o);
    e = model(0, 10, 0, 40'd4, 40'd64);
    checks++; if (fmt(o) != fmt(e)) begin errors++; $display("FAIL fwd_model: got %s want %s", fmt(o), fmt(e)); end
    checks++; if (o.nreq != 5 || o.k !== 40'd4 || o.s !== 40'd4 || o.beg != 0 || o.fin != 4)
      begin errors++; $display("FAIL fwd_directed: got %s want k=4 s=4 beg=0 end=4 req=5", fmt(o)); end
    checks++; if (o.busy_after !== 1'b0) begin errors++; $display("FAIL fwd_busy_drop: got %b want 0", o.busy_after); end
  endtask

  task automatic test_backward();
    res_t o, e;
    run(1, 10, 9, 40'd4, o);
    e = model(1, 10, 9, 40'd4, 40'd64);
    checks++; if (fmt(o) != fmt(e)) begin errors++; $display("FAIL bwd_model: got %s want %s", fmt(o), fmt(e)); end
    checks++; if (o.beg != 6 || o.fin != 10 || o.s !== 40'd4 || o.nreq != 5)
      begin errors++; $display("FAIL bwd_directed: got %s want s=4 beg=6 end=10 req=5", fmt(o)); end
  endtask

  task automatic test_bidir();
    res_t o, e;
    run(2, 6, 5, 40'd1, o);
    e = model(2, 6, 5, 40'd1, 40'd64);
    checks++; if (fmt(o) != fmt(e)) begin errors++; $display("FAIL bidir_model: got %s want %s", fmt(o), fmt(e)); end
    checks++; if (o.beg != 0 || o.fin != 6 || o.s !== 40'd1 || o.nreq != 6)
      begin errors++; $display("FAIL bidir_directed: got %s want s=1 beg=0 end=6 req=6", fmt(o)); end
  endtask

  task automatic test_ambiguous();
    res_t o, e;
    qbuf[2] = 3'd4; load_query(10);
    run(0, 10, 0, 40'd1, o);
    e = model(0, 10, 0, 40'd1, 40'd64);
    checks++; if (fmt(o) != fmt(e)) begin errors++; $display("FAIL ambig_model: got %s want %s", fmt(o), fmt(e)); end
    checks++; if (o.nreq != 2 || o.fin != 2 || o.s !== 40'd16)
      begin errors++; $display("FAIL ambig_directed: got %s want end=2 s=16 req=2", fmt(o)); end
    qbuf[2] = 3'd0; load_query(10);
  endtask

  task automatic test_edges();
    res_t o;
    run(0, 10, 10, 40'd4, o);
    checks++; if (o.lat != 2) begin errors++; $display("FAIL edge_latency: got %0d want 2", o.lat); end
    checks++; if (o.nreq != 0 || o.beg != 10 || o.fin != 10 || o.s !== 40'd64 || o.k !== 40'd0)
      begin errors++; $display("FAIL edge_pivot_eq_len: got %s want s=64 beg=10 end=10 req=0", fmt(o)); end
    run(2, 0, 3, 40'd4, o);
    checks++; if (o.nreq != 0 || o.beg != 3 || o.fin != 3 || o.s !== 40'd64)
      begin errors++; $display("FAIL edge_zero_len: got %s want s=64 beg=3 end=3 req=0", fmt(o)); end
  endtask

  task automatic test_busy_ignore();
    res_t o, e;
    int rbase;
    rbase = n_res;
    kick(0, 10, 0, 40'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      q_wr = 1'b1; q_addr = AW'(i); q_sym = 3'd5; start = 1'b1; mode = 2'd1; pivot = AW'(3);
    end
    @(negedge clk); q_wr = 1'b0; start = 1'b0;
    wait_result(o);
    e = model(0, 10, 0, 40'd1, 40'd64);
    checks++; if (fmt(o) != fmt(e)) begin errors++; $display("FAIL busy_run: got %s want %s", fmt(o), fmt(e)); end
    checks++; if (n_res - rbase != 1) begin errors++; $display("FAIL busy_restart: got %0d results want 1", n_res - rbase); end
    run(0, 10, 0, 40'd1, o);
    checks++; if (fmt(o) != fmt(e)) begin errors++; $display("FAIL busy_buffer_kept: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_reset_mid();
    res_t o, e;
    int rbase;
    bit seen = 1'b0;
    rbase = n_res;
    kick(0, 10, 0, 40'd4);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_req > req_base) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_no_request: got 0 requests want 1"); end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({busy, ext_start, res_valid} !== 3'b000 || ext_s !== '0)
      begin errors++; $display("FAIL midrst_outputs: got busy=%b st=%b rv=%b ext_s=%0d want 0", busy, ext_start, res_valid, ext_s); end
    @(negedge clk); rst_n = 1'b1;
    inj_req++;
    repeat (10) @(negedge clk);
    checks++; if (n_res != rbase || busy !== 1'b0 || res_s !== '0 || ext_k !== '0)
      begin errors++; $display("FAIL midrst_late_finish: got results=%0d busy=%b res_s=%0d want 0", n_res - rbase, busy, res_s); end
    set_bwt(40'd64); fill_a(10); load_query(10);
    run(0, 10, 0, 40'd4, o);
    e = model(0, 10, 0, 40'd4, 40'd64);
    checks++; if (fmt(o) != fmt(e) || o.fin != 4 || o.s !== 40'd4)
      begin errors++; $display("FAIL midrst_rerun: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_random();
    res_t o, e;
    int ql, pv, md;
    kls_t bwt, mv;
    for (int it = 0; it < 30; it++) begin
      ql  = $urandom_range(0, 24);
      pv  = $urandom_range(0, ql + 1);
      md  = $urandom_range(0, 3);
      bwt = kls_t'({$urandom(), $urandom()}) >> $urandom_range(0, 39);
      mv  = ($urandom_range(0, 3) == 0) ? '0 : (bwt >> $urandom_range(1, 30));
      core_lat = $urandom_range(1, 5);
      for (int i = 0; i < ql; i++)
        qbuf[i] = ($urandom_range(0, 9) == 0) ? SYM_W'($urandom_range(4, 7)) : SYM_W'($urandom_range(0, 3));
      set_bwt(bwt);
      if (ql > 0) load_query(ql);
      run(md, ql, pv, mv, o);
      e = model(md, ql, pv, mv, bwt);
      checks++;
      if (fmt(o) != fmt(e) || o.busy_after !== 1'b0)
        begin errors++; $display("FAIL random_%0d md=%0d ql=%0d pv=%0d: got %s busy=%b want %s", it, md, ql, pv, fmt(o), o.busy_after, fmt(e)); end
    end
    core_lat = 3;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backward();
    test_bidir();
    test_ambiguous();
    test_edges();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
